// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port CPU-to-data-memory access sequencer.
// Loads drive mem_read for 1+WAIT_CYCLES cycles and then capture mem_rdata. Stores go through
// setup, strobe and hold phases so that mem_write has exactly one rising edge per store. Every
// output is a flop, and each one is loaded from the next-state decode.
// Optional feature macro: MEM_ACCESS_UNIT_BYTE_EN (adds byte loads and read-modify-write byte
// stores).
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
`ifdef MEM_ACCESS_UNIT_BYTE_EN
  input  logic        req_byte,
  input  logic        req_bsel,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata
);

  localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StSetup,
    StStrobe,
    StHold,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [15:0] addr_d, wdata_d, rdata_d;

`ifdef MEM_ACCESS_UNIT_BYTE_EN
  // Request attributes kept for the whole operation, since req_* are ignored after acceptance.
  logic       byte_q, byte_d;
  logic       bsel_q, bsel_d;
  logic       store_q, store_d;
  logic [7:0] wbyte_q, wbyte_d;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = resp_rdata;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
    byte_d  = byte_q;
    bsel_d  = bsel_q;
    store_d = store_q;
    wbyte_d = wbyte_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          wait_d = 3'd0;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
          byte_d  = req_byte;
          bsel_d  = req_bsel;
          store_d = req_write;
          wbyte_d = req_wdata[7:0];
          // A byte store must first read the word it is going to merge into.
          if (req_write && !req_byte) begin
            state_d = StSetup;
            wdata_d = req_wdata;
          end else begin
            state_d = StRd;
          end
`else
          if (req_write) begin
            state_d = StSetup;
            wdata_d = req_wdata;
          end else begin
            state_d = StRd;
          end
`endif
        end
      end
      StRd: begin
        if (wait_q == WaitLast) begin
`ifdef MEM_ACCESS_UNIT_BYTE_EN
          if (store_q) begin
            state_d = StSetup;
            wdata_d = bsel_q ? {wbyte_q, mem_rdata[7:0]} : {mem_rdata[15:8], wbyte_q};
          end else begin
            state_d = StResp;
            if (byte_q) begin
              rdata_d = bsel_q ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
            end else begin
              rdata_d = mem_rdata;
            end
          end
`else
          state_d = StResp;
          rdata_d = mem_rdata;
`endif
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold:   state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register and registered outputs, all loaded from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_q     <= 3'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      resp_rdata <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      req_ready  <= (state_d == StIdle);
      resp_valid <= (state_d == StResp);
      mem_read   <= (state_d == StRd);
      mem_write  <= (state_d == StStrobe);
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      resp_rdata <= rdata_d;
    end
  end

`ifdef MEM_ACCESS_UNIT_BYTE_EN
  // Captured byte-access attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q  <= 1'b0;
      bsel_q  <= 1'b0;
      store_q <= 1'b0;
      wbyte_q <= 8'h00;
    end else begin
      byte_q  <= byte_d;
      bsel_q  <= bsel_d;
      store_q <= store_d;
      wbyte_q <= wbyte_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit. It runs two instances, one with WAIT_CYCLES=0 and one with
// WAIT_CYCLES=3, and each instance has its own memory model. Expected read data comes from a
// transaction-level memory kept in an associative array.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv[2], rw[2];
  logic [15:0] ra[2], rwd[2];
  logic        rr[2], resp_v[2], mr[2], mw[2];
  logic [15:0] resp_d[2], ma[2], mwd[2], mrd[2];
`ifdef MEM_ACCESS_UNIT_BYTE_EN
  logic        rb[2], rbs[2];
`endif

  logic [15:0] mem0[0:65535];
  logic [15:0] mem1[0:65535];
  int          wr_edges[2] = '{0, 0};
  int          ovl_bad = 0;
  int          total = 0;
  int          bad = 0;

  mem_access_unit #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]),
`ifdef MEM_ACCESS_UNIT_BYTE_EN
    .req_byte(rb[0]), .req_bsel(rbs[0]),
`endif
    .req_ready(rr[0]), .resp_valid(resp_v[0]), .resp_rdata(resp_d[0]), .mem_addr(ma[0]),
    .mem_wdata(mwd[0]), .mem_read(mr[0]), .mem_write(mw[0]), .mem_rdata(mrd[0])
  );

  mem_access_unit #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]),
`ifdef MEM_ACCESS_UNIT_BYTE_EN
    .req_byte(rb[1]), .req_bsel(rbs[1]),
`endif
    .req_ready(rr[1]), .resp_valid(resp_v[1]), .resp_rdata(resp_d[1]), .mem_addr(ma[1]),
    .mem_wdata(mwd[1]), .mem_read(mr[1]), .mem_write(mw[1]), .mem_rdata(mrd[1])
  );

  // Memories: combinational read while mem_read is high, write on the mem_write rising edge.
  assign mrd[0] = mr[0] ? mem0[ma[0]] : 16'h0000;
  assign mrd[1] = mr[1] ? mem1[ma[1]] : 16'h0000;

  always @(posedge mw[0]) begin
    mem0[ma[0]] <= mwd[0];
    wr_edges[0] <= wr_edges[0] + 1;
  end

  always @(posedge mw[1]) begin
    mem1[ma[1]] <= mwd[1];
    wr_edges[1] <= wr_edges[1] + 1;
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) if (mr[u] && mw[u]) ovl_bad <= ovl_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Transaction-level reference memory, keyed by unit*65536 + address.
  logic [15:0] refm[int];

  function automatic logic [15:0] ref_get(input int u, input logic [15:0] a);
    int k = u * 65536 + int'(a);
    return refm.exists(k) ? refm[k] : 16'h0000;
  endfunction

  function automatic void ref_put(input int u, input logic [15:0] a, input logic [15:0] d);
    refm[u * 65536 + int'(a)] = d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s u%0d ctl", tag, u), {28'd0, rr[u], resp_v[u], mr[u], mw[u]}, 32'h8);
      chk($sformatf("%s u%0d addr", tag, u), {16'd0, ma[u]}, 32'h0);
      chk($sformatf("%s u%0d wdata", tag, u), {16'd0, mwd[u]}, 32'h0);
      chk($sformatf("%s u%0d rdata", tag, u), {16'd0, resp_d[u]}, 32'h0);
    end
  endtask

  // Called at a falling edge; the request is accepted on the next rising edge (edge 0).
  task automatic issue(input int u, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    while (!rr[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d ready_wait", u), {31'd0, rr[u]}, 32'h1);
    rv[u]  = 1'b1;
    rw[u]  = wr;
    ra[u]  = a;
    rwd[u] = d;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
    rb[u]  = 1'b0;
    rbs[u] = 1'b0;
`endif
  endtask

  // Checks cycles 1..last after acceptance against the expected timeline. Request inputs get
  // junk while the unit is busy. With chain set, req_valid stays high and the next request is
  // presented in the first idle cycle.
  task automatic observe(input int u, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd, input bit chain,
                         input logic nwr, input logic [15:0] na, input logic [15:0] nd);
    int         w    = (u == 0) ? 0 : 3;
    int         last = wr ? 5 : 3 + w;
    int         e0   = wr_edges[u];
    logic [3:0] ectl;
    string      tag;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      tag = $sformatf("u%0d %s a=%h k=%0d", u, wr ? "st" : "ld", a, k);
      if (wr) ectl = {k == 5, k == 4, 1'b0, k == 2};
      else    ectl = {k == last, k == 2 + w, k <= 1 + w, 1'b0};
      chk({tag, " ctl"}, {28'd0, rr[u], resp_v[u], mr[u], mw[u]}, {28'd0, ectl});
      chk({tag, " addr"}, {16'd0, ma[u]}, {16'd0, a});
      if (wr) chk({tag, " wdata"}, {16'd0, mwd[u]}, {16'd0, d});
      else if (k >= 2 + w) chk({tag, " rdata"}, {16'd0, resp_d[u]}, {16'd0, exp_rd});
      if (k < last) begin
        if (chain) begin
          rv[u] = 1'b1;
        end else begin
          rv[u]  = 1'($urandom);
          rw[u]  = 1'($urandom);
          ra[u]  = 16'($urandom);
          rwd[u] = 16'($urandom);
        end
      end else if (chain) begin
        rw[u]  = nwr;
        ra[u]  = na;
        rwd[u] = nd;
      end else begin
        rv[u] = 1'b0;
      end
    end
    chk($sformatf("u%0d a=%h write_edges", u, a), 32'(wr_edges[u] - e0), wr ? 32'd1 : 32'd0);
    if (wr) ref_put(u, a, d);
  endtask

`ifdef MEM_ACCESS_UNIT_BYTE_EN
  task automatic byte_op(input logic wr, input logic by, input logic bs, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] rd);
    int n = 0;
    issue(0, wr, a, d);
    rb[0]  = by;
    rbs[0] = bs;
    @(negedge clk);
    rv[0] = 1'b0;
    while (!resp_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("byte op a=%h resp", a), {31'd0, resp_v[0]}, 32'h1);
    rd = resp_d[0];
    @(negedge clk);
  endtask
`endif

  typedef struct {
    int          u;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        tv[9];
  logic [15:0] pool[8] = '{16'h0000, 16'h0001, 16'h00FF, 16'h1000,
                           16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFF};

  initial begin
    int          nresp;
    int          u;
    logic        wr;
    logic [15:0] a, d;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
    logic [15:0] r;
`endif

    tv[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    tv[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tv[2] = '{0, 1'b1, 16'hFFFF, 16'h1357, 16'h0000};
    tv[3] = '{0, 1'b1, 16'h0000, 16'h2468, 16'h0000};
    tv[4] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'h1357};
    tv[5] = '{0, 1'b0, 16'h0000, 16'h0000, 16'h2468};
    tv[6] = '{1, 1'b1, 16'h0010, 16'hCAFE, 16'h0000};
    tv[7] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hCAFE};
    tv[8] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};

    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i]  = 1'b0;
      rw[i]  = 1'b0;
      ra[i]  = 16'h0000;
      rwd[i] = 16'h0000;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
      rb[i]  = 1'b0;
      rbs[i] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    chk_reset("por");

    // The first table entry is presented as rst drops, so it must be taken on the first edge.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      issue(tv[i].u, tv[i].wr, tv[i].a, tv[i].d);
      observe(tv[i].u, tv[i].wr, tv[i].a, tv[i].d, tv[i].exp, 1'b0, 1'b0, 16'h0, 16'h0);
    end

    // Back-to-back: req_valid held high across a store and the following load.
    issue(0, 1'b1, 16'h0040, 16'h0F0F);
    observe(0, 1'b1, 16'h0040, 16'h0F0F, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    observe(0, 1'b0, 16'h0040, 16'h0, 16'h0F0F, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset during SETUP: no write may reach memory.
    issue(0, 1'b1, 16'h0020, 16'h1234);
    nresp = wr_edges[0];
    @(negedge clk);
    rst   = 1'b1;
    rv[0] = 1'b0;
    #1;
    chk_reset("rst_setup");
    @(negedge clk);
    rst = 1'b0;
    chk("rst_setup write_edges", 32'(wr_edges[0] - nresp), 32'd0);
    issue(0, 1'b0, 16'h0020, 16'h0);
    observe(0, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset during STROBE: the write already happened, but no response may follow.
    issue(0, 1'b1, 16'h0030, 16'h5A5A);
    repeat (2) @(negedge clk);
    chk("strobe before reset", {31'd0, mw[0]}, 32'h1);
    rst   = 1'b1;
    rv[0] = 1'b0;
    #1;
    chk_reset("rst_strobe");
    ref_put(0, 16'h0030, 16'h5A5A);
    @(negedge clk);
    rst   = 1'b0;
    nresp = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_v[0]) nresp++;
    end
    chk("rst_strobe no resp", 32'(nresp), 32'd0);
    issue(0, 1'b0, 16'h0030, 16'h0);
    observe(0, 1'b0, 16'h0030, 16'h0, ref_get(0, 16'h0030), 1'b0, 1'b0, 16'h0, 16'h0);

    // Random traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      u  = int'($urandom_range(1, 0));
      wr = 1'($urandom);
      a  = pool[$urandom_range(7, 0)];
      d  = 16'($urandom);
      issue(u, wr, a, d);
      observe(u, wr, a, d, ref_get(u, a), 1'b0, 1'b0, 16'h0, 16'h0);
    end

`ifdef MEM_ACCESS_UNIT_BYTE_EN
    byte_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, r);
    byte_op(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0055, r);
    chk("byte store merged word", {16'd0, mem0[16'h0010]}, 32'h0000BE55);
    byte_op(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, r);
    chk("byte load upper", {16'd0, r}, 32'h000000BE);
    byte_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, r);
    chk("byte load lower", {16'd0, r}, 32'h00000055);
    byte_op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, r);
    chk("word load after byte store", {16'd0, r}, 32'h0000BE55);
`endif

    @(negedge clk);
    chk("read/write overlap cycles", 32'(ovl_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, meaning extra cycles mem_read is held before read data is captured (0..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  16  word address.
REQ-007 req_wdata  input  16  store data.
REQ-008 req_ready  output  1  unit can accept a request this cycle.
REQ-009 resp_valid  output  1  one-cycle completion pulse (loads and stores).
REQ-010 resp_rdata  output  16  load result, valid while resp_valid=1.
REQ-011 mem_addr  output  16  to data memory address.
REQ-012 mem_wdata  output  16  to data memory write data.
REQ-013 mem_read  output  1  to data memory read enable (level).
REQ-014 mem_write  output  1  to data memory write strobe; memory samples on its rising edge.
REQ-015 mem_rdata  input  16  from data memory read data (combinational w.r.t. mem_addr/mem_read).

Function
REQ-016 All outputs SHALL be registered; states IDLE, RD, SETUP, STROBE, HOLD, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready at a rising edge (edge 0); no request queuing.
REQ-018 Store: IDLE->SETUP (mem_addr/mem_wdata driven, mem_write=0)->STROBE (mem_write=1)->HOLD (mem_write=0, addr/data held)->RESP->IDLE; resp_valid high in the cycle after edge 3.
REQ-019 mem_addr and mem_wdata SHALL be stable from SETUP through HOLD inclusive; exactly one mem_write rising edge per store.
REQ-020 Load: IDLE->RD (mem_read=1 for 1+WAIT_CYCLES cycles)->RESP; mem_rdata captured into resp_rdata on the edge leaving RD; resp_valid high in the cycle after edge 1+WAIT_CYCLES.
REQ-021 RESP SHALL last exactly one cycle (no back-pressure), then IDLE; req_ready rises the cycle after RESP.
REQ-022 In IDLE: mem_read=0, mem_write=0, resp_valid=0; mem_addr, mem_wdata, resp_rdata hold last values.
REQ-023 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-024 req_* inputs SHALL be ignored outside IDLE; changes during an operation do not affect it.
REQ-025 Address 16'hFFFF and 16'h0000 SHALL be handled identically to any other address (no wrap logic).

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, req_ready=1, resp_valid=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, resp_rdata=0.
REQ-027 Reset in SETUP or RD SHALL produce no mem_write rising edge; reset in STROBE/HOLD SHALL abort with no resp_valid.
REQ-028 First request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro MEM_ACCESS_UNIT_BYTE_EN: when defined, adds inputs req_byte (1) and req_bsel (1, 1=upper byte); byte load zero-extends the selected byte; byte store performs RD (read word) then SETUP/STROBE/HOLD with only the selected byte replaced, one resp_valid at end.
REQ-030 When MEM_ACCESS_UNIT_BYTE_EN is undefined, ports req_byte/req_bsel SHALL not exist and all accesses are full 16-bit words.

Verification
REQ-031 Store addr 16'h0010 data 16'hBEEF -> mem_write high exactly cycle 2 after accept, mem_addr=16'h0010 cycles 1..3, resp_valid at cycle 4.
REQ-032 Load addr 16'h0010 after REQ-031, WAIT_CYCLES=0 -> mem_read cycle 1 only, resp_rdata=16'hBEEF with resp_valid at cycle 2; WAIT_CYCLES=3 -> resp_valid at cycle 5.
REQ-033 Back-to-back req_valid held high for store then load -> second accepted cycle after RESP; req_ready=0 throughout first op.
REQ-034 rst asserted during SETUP of store to 16'h0020 data 16'h1234 -> mem_write never rises, subsequent load of 16'h0020 returns 16'h0000.
REQ-035 With MEM_ACCESS_UNIT_BYTE_EN: word 16'hBEEF at 16'h0010, byte store bsel=0 data 16'h0055 -> memory holds 16'hBE55; byte load bsel=1 -> resp_rdata=16'h00BE.
